div_unit: RTL and testbench

- Iterative 32-bit integer divider used by the execute stage, directly downstream of instruction decode.
- Consumes the two source operands that decode forwards (rs → opdata1_i, rt → opdata2_i) when decode selects a DIV/DIVU operation.
- Produces the 64-bit {HI, LO} result through a start/ready handshake, taking 33 clocks per divide.
- The execute stage stalls the pipeline while a divide is in progress.

---
 rtl/div_unit.sv | 175 +++++++++++++++++
 tb/tb_div_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- iterative 32-bit integer divider (DIV / DIVU) for the execute
// stage. One quotient bit is produced per clock using restoring
// shift-subtract. A divide takes 33 clocks from the start edge to ready_o.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous reset, active-low
//   signed_div_i  1 = signed divide, 0 = unsigned; sampled with start_i
//   opdata1_i     dividend (rs); sampled with start_i
//   opdata2_i     divisor (rt); sampled with start_i
//   start_i       divide request, held high until ready_o is seen
//   annul_i       cancel the in-flight divide
//   result_o      {remainder (HI), quotient (LO)}; registered
//   ready_o       result valid level flag; registered
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    // {partial remainder, dividend}: remainder lives in [2W:W+1], the
    // quotient bits shift in at [0] and end up in [W-1:0].
    logic [2*DATA_W:0]   work_q, work_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                signed_q, signed_d;
    logic                dvd_neg_q, dvd_neg_d;
    logic                dvs_neg_q, dvs_neg_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   op1_abs;
    logic [DATA_W-1:0]   op2_abs;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;

        // Magnitudes wrap modulo 2^W, so abs(most negative) stays 2^(W-1)
        // which is exactly right when treated as unsigned.
        op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

        // 33-bit trial subtraction: the shifted partial remainder can reach
        // 2*divisor-1, which overflows W bits for divisors >= 2^(W-1).
        trial = work_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};

        // Quotient negated when operand signs differ; remainder follows
        // the dividend sign (truncation toward zero).
        quo_fix = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ? (~work_q[DATA_W-1:0] + 1'b1)
                                                        : work_q[DATA_W-1:0];
        rem_fix = (signed_q && dvd_neg_q) ? (~work_q[2*DATA_W:DATA_W+1] + 1'b1)
                                          : work_q[2*DATA_W:DATA_W+1];

        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d   = ON;
                        cnt_d     = 6'd0;
                        signed_d  = signed_div_i;
                        dvd_neg_d = signed_div_i & opdata1_i[DATA_W-1];
                        dvs_neg_d = signed_div_i & opdata2_i[DATA_W-1];
                        divisor_d = op2_abs;
                        work_d    = {{DATA_W{1'b0}}, op1_abs, 1'b0};
                    end
                end
            end

            BYZERO: begin
                if (annul_i) begin
                    state_d = FREE;
                end else begin
                    state_d  = END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end

            ON: begin
                if (annul_i) begin
                    state_d  = FREE;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q == 6'd32) begin
                    // Finishing edge: no iteration, only sign fix-up and load.
                    state_d  = END;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end else begin
                    if (trial[DATA_W]) begin
                        // Trial went negative: restore by simply shifting.
                        work_d = {work_q[2*DATA_W-1:0], 1'b0};
                    end else begin
                        work_d = {trial[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end
            end

            END: begin
                if (!start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d = FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FREE;
            cnt_q     <= 6'd0;
            work_q    <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit -- directed self-checking bench for div_unit. Inputs change
// and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    // Full divide transaction: start, scramble operands after the start
    // edge, wait for ready with a bound, check latency/result, hold in END
    // (with a stray annul that must be ignored), then release.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        tick();
        op1        = ~a;
        op2        = 32'h5;
        signed_div = ~sgn;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_result"}, result, exp);
        annul = 1'b1;
        tick();
        annul = 1'b0;
        check({tag, "_hold_ready"}, {63'd0, ready}, 64'd1);
        check({tag, "_hold_result"}, result, exp);
        start = 1'b0;
        tick();
        check({tag, "_drop_ready"}, {63'd0, ready}, 64'd0);
        check({tag, "_drop_result"}, result, 64'd0);
        $display("div %s: sgn=%0d a=0x%08h b=0x%08h latency=%0d result=0x%016h", tag, sgn, a, b, n, exp);
    endtask

    initial begin
        int n;
        int seen;

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b1;
        annul = 1'b1;
        tick();
        annul = 1'b0;
        tick();
        check("idle_ready", {63'd0, ready}, 64'd0);
        $display("reset: ready=%0d result=0x%016h", ready, result);

        // Basic divides
        do_div("u_7_2",      1'b0, 32'h00000007, 32'h00000002, 64'h00000001_00000003, 33);
        do_div("s_m7_2",     1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
        do_div("s_7_m2",     1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
        do_div("s_m7_m2",    1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33);
        do_div("s_ovf",      1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        do_div("u_ovf_ops",  1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33);
        do_div("u_max_1",    1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 33);
        do_div("u_big_dvs",  1'b0, 32'hFFFFFFFF, 32'h80000001, 64'h7FFFFFFE_00000001, 33);
        do_div("s_divzero",  1'b1, 32'h00001234, 32'h00000000, 64'h00000000_00000000, 1);
        do_div("u_divzero",  1'b0, 32'hFFFFFFFF, 32'h00000000, 64'h00000000_00000000, 1);

        // Annul mid-divide: ready must never rise afterwards
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd3;
        start = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        annul = 1'b0;
        check("annul_ready", {63'd0, ready}, 64'd0);
        check("annul_result", result, 64'd0);
        seen = 0;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (ready) seen++;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        $display("annul: divide cancelled at iteration 10, ready pulses seen=%0d", seen);
        do_div("u_100_7",    1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

        // Annul while in BYZERO
        op1 = 32'd9;
        op2 = 32'd0;
        start = 1'b1;
        tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        annul = 1'b0;
        tick();
        check("annul_byzero_ready", {63'd0, ready}, 64'd0);
        $display("annul in divide-by-zero: ready=%0d", ready);

        // Reset mid-divide at iteration 20, start kept high through reset
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd3;
        start = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b0;
        tick();
        check("midreset_ready", {63'd0, ready}, 64'd0);
        check("midreset_result", result, 64'd0);
        rst = 1'b1;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        check("postreset_latency", 64'(n), 64'd34);
        check("postreset_result", result, 64'h00000001_0000014D);
        start = 1'b0;
        tick();
        check("postreset_drop_ready", {63'd0, ready}, 64'd0);
        $display("reset mid-divide: restart latency=%0d result=0x%016h", n, result);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
